// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder slice.
//   NIB_W     : datapath width of the single ripple adder stage
//   state_e   : sequencer states (2'd3 is unused and recovers to IDLE)
//   width_ok  : operand-width legality check used at elaboration
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operand width must be a whole, non-zero number of nibbles.
    function automatic bit width_ok(input int unsigned w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a datapath (master) and the serial adder (slave).
//   start/A/B/cin : request and operands, sampled on the accepting edge
//   ready         : adder can accept a request
//   S/cout/ovf    : registered result, valid from the done cycle on
//   done          : one-cycle completion pulse
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;
    logic             done;

    modport master (
        output start, A, B, cin,
        input  ready, S, cout, ovf, done
    );

    modport slave (
        input  start, A, B, cin,
        output ready, S, cout, ovf, done
    );
endinterface

// File: rtl/nibble_serial_adder_ripple_4bit.sv
// 4-bit ripple-carry adder, the nibble datapath of the serial adder.
//   a_i, b_i : nibble operands
//   cin_i    : carry in
//   sum_o    : nibble sum
//   cout_o   : carry out of bit 3
module ripple_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] c;

    always_comb begin
        c[0] = cin_i;
        sum_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[4];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one ripple_4bit stage, one nibble per clock,
// LSB nibble first, with a registered carry linking the nibbles.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of nibble_serial_adder_if (start/A/B/cin in,
//          ready/S/cout/ovf/done out)
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned CNT_W   = $clog2(NIBBLES) + 1;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
        end
    endgenerate

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ready_q;
    logic             done_q;

    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;
    logic             last_nib;

    ripple_4bit u_nib (
        .a_i    (a_q[NIB_W-1:0]),
        .b_i    (b_q[NIB_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    // New nibble enters at the MSB end; after NIBBLES shifts the first
    // nibble has arrived at bits [3:0].
    always_comb begin
        acc_d    = (acc_q >> NIB_W) | (WIDTH'(nib_sum) << (WIDTH - NIB_W));
        last_nib = (cnt_q == CNT_W'(NIBBLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        a_msb_q <= bus.A[WIDTH-1];
                        b_msb_q <= bus.B[WIDTH-1];
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= nib_cout;
                    a_q     <= a_q >> NIB_W;
                    b_q     <= b_q >> NIB_W;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        s_q     <= acc_d;
                        cout_q  <= nib_cout;
                        ovf_q   <= (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.S     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    localparam int unsigned W = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   done_cnt;
    int   exp_done_cnt;
    logic [W-1:0] prev_s;
    logic         prev_cout;
    logic         prev_ovf;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One add. Entered #1 after an edge with the block expected ready.
    // interfere: assert a bogus start on the second RUN edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit interfere);
        logic [W:0] full;
        logic       exp_ovf;
        int         n;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        check("ready_before_start", 32'(bus.ready), 32'd1);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.cin   = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.cin   = 1'($urandom);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            check("ready_low_in_run", 32'(bus.ready), 32'd0);
            check("s_hold_in_run", 32'(bus.S), 32'(prev_s));
            check("cout_hold_in_run", 32'(bus.cout), 32'(prev_cout));
            if (interfere && n == 1) begin
                bus.start = 1'b1;
                bus.A     = 16'hAAAA;
                bus.B     = 16'h5555;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end
        exp_done_cnt++;
        check("latency_edges", 32'(n), 32'd4);
        check("done_pulse", 32'(bus.done), 32'd1);
        check("ready_in_done", 32'(bus.ready), 32'd1);
        check("sum", 32'(bus.S), 32'(full[W-1:0]));
        check("cout", 32'(bus.cout), 32'(full[W]));
        check("ovf", 32'(bus.ovf), 32'(exp_ovf));
        prev_s    = full[W-1:0];
        prev_cout = full[W];
        prev_ovf  = exp_ovf;
    endtask

    // One cycle with start low after a done: pulse must drop, result hold.
    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check("done_drops", 32'(bus.done), 32'd0);
        check("ready_idle", 32'(bus.ready), 32'd1);
        check("s_hold_idle", 32'(bus.S), 32'(prev_s));
        check("ovf_hold_idle", 32'(bus.ovf), 32'(prev_ovf));
    endtask

    initial begin
        int t0;
        int saved;
        total = 0;
        bad = 0;
        done_cnt = 0;
        exp_done_cnt = 0;
        prev_s = '0;
        prev_cout = 1'b0;
        prev_ovf = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.cin = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_s", 32'(bus.S), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle_cycle();

        // Back-to-back: second start issued in the first done cycle.
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        t0 = $time;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        check("b2b_spacing_edges", 32'(($time - t0) / 10), 32'd5);
        check("b2b_sum_literal", 32'(bus.S), 32'h1000);
        idle_cycle();

        // start during RUN must be ignored.
        run_op(16'h0001, 16'h0001, 1'b0, 1'b1);
        check("busy_sum_literal", 32'(bus.S), 32'h0002);
        idle_cycle();
        repeat (6) idle_cycle();
        check("one_done_per_op", 32'(done_cnt), 32'(exp_done_cnt));

        // Asynchronous reset in the middle of RUN.
        bus.start = 1'b1;
        bus.A = 16'h1111;
        bus.B = 16'h2222;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(bus.ready), 32'd1);
        check("async_rst_s", 32'(bus.S), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        #1;
        rst = 1'b0;
        prev_s = '0;
        prev_cout = 1'b0;
        prev_ovf = 1'b0;
        saved = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("no_done_after_rst", 32'(done_cnt), 32'(saved));
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        check("post_rst_sum_literal", 32'(bus.S), 32'h0100);
        idle_cycle();

        // Randomized adds, mixing idle gaps and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
        check("done_count_total", 32'(done_cnt), 32'(exp_done_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
